// File: rtl/ppu_line_doubler.sv
// Two-bank scanline buffer between the PPU palette lookup and the VGA controller.
// Each 256-px line is replayed at 2x in both axes, centred in the 640x480 frame.
module ppu_line_doubler #(
    parameter int               LINE_W   = 256,
    parameter int               PIX_W    = 6,
    parameter int               H_OFFSET = 64,
    parameter logic [PIX_W-1:0] BORDER   = 'h0F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             ready,
    input  logic             pix_ce,
    input  logic [9:0]       draw_x,
    input  logic [9:0]       draw_y,
    output logic [PIX_W-1:0] palette_idx,
    output logic             overrun,
    output logic             underrun
);

    localparam int AW = $clog2(LINE_W);

    typedef enum logic [1:0] {
        S_WAIT,
        S_LINE0,
        S_LINE1,
        S_STARVE
    } state_t;

    state_t           state, state_next;
    logic [AW-1:0]    wr_x;
    logic             wr_bank, rd_bank;
    logic [1:0]       full_cnt, full_next;
    logic             accept, wr_done, line_end, frame_top, rd_release;
    logic             in_window, show, starving;
    logic [AW-1:0]    rd_addr;

    logic [PIX_W-1:0] mem [2*LINE_W];

    assign ready      = (full_cnt != 2'd2);
    assign accept     = pix_valid && ready && !frame_start;
    assign wr_done    = accept && (wr_x == AW'(LINE_W - 1));
    assign line_end   = pix_ce && (draw_x == 10'd799);
    assign frame_top  = pix_ce && (draw_x == 10'd0) && (draw_y == 10'd0);
    assign rd_release = line_end && (state == S_LINE1);

    assign in_window = (draw_x >= 10'(H_OFFSET)) &&
                       (draw_x <  10'(H_OFFSET + 2*LINE_W)) &&
                       (draw_y <  10'd480);
    assign rd_addr   = AW'((draw_x - 10'(H_OFFSET)) >> 1);

    // A completed write and a released bank on the same clock cancel out.
    always_comb begin
        // NOTE: assign every always_comb output up front so no path leaves it unassigned (no latch).
        full_next = full_cnt;
        if (wr_done && !rd_release)
            full_next = full_cnt + 2'd1;
        else if (!wr_done && rd_release && full_cnt != 2'd0)
            full_next = full_cnt - 2'd1;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset)
            state <= S_WAIT;
        else
            state <= state_next;
    end

    // Next-state logic; an empty buffer at frame top starves the first row pair
    // so a line that arrives late still appears two rows further down.
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:
                if (frame_top)
                    state_next = (full_cnt != 2'd0) ? S_LINE0 : S_STARVE;
            S_LINE0:
                if (line_end)
                    state_next = S_LINE1;
            S_LINE1:
                if (line_end) begin
                    if (draw_y == 10'd479)
                        state_next = S_WAIT;
                    else if (full_next != 2'd0)
                        state_next = S_LINE0;
                    else
                        state_next = S_STARVE;
                end
            S_STARVE:
                if (line_end && draw_y[0] && full_next != 2'd0)
                    state_next = S_LINE0;
            default:
                state_next = S_WAIT;
        endcase
        if (frame_start)
            state_next = S_WAIT;
    end

    // Output decode
    always_comb begin
        show     = in_window && (state == S_LINE0 || state == S_LINE1);
        starving = pix_ce && ((state == S_STARVE) ||
                              (state == S_WAIT && frame_top && full_cnt == 2'd0));
    end

    // Write pointer, bank occupancy and read bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_x     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full_cnt <= 2'd0;
        end else if (frame_start) begin
            wr_x     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full_cnt <= 2'd0;
        end else begin
            full_cnt <= full_next;
            if (accept) begin
                wr_x <= wr_x + 1'b1;
                if (wr_done)
                    wr_bank <= ~wr_bank;
            end
            if (rd_release)
                rd_bank <= ~rd_bank;
        end
    end

    // NOTE: the line store has no reset; it is always written before it is displayed.
    always_ff @(posedge clk) begin
        if (accept)
            mem[{wr_bank, wr_x}] <= pix_data;
    end

    // Registered output: synchronous bank read, one pix_ce tick behind draw_x.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            palette_idx <= BORDER;
        else if (pix_ce)
            palette_idx <= show ? mem[{rd_bank, rd_addr}] : BORDER;
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (pix_valid && !ready)
                overrun <= 1'b1;
            if (starving)
                underrun <= 1'b1;
        end
    end

endmodule
